// File: rtl/tv_channel_ctrl.sv
// IR-driven TV channel controller: power, CH+/CH-, recall and two-digit entry.
// Drives a five-nibble BCD bundle for the 7-segment display driver.
module tv_channel_ctrl #(
    parameter int CH_MIN        = 1,
    parameter int CH_MAX        = 64,
    parameter int CH_W          = 7,
    parameter int WRAP          = 0,
    parameter int ENTRY_TIMEOUT = 50_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      ir_cmd,
    input  logic            ir_valid,
    output logic [19:0]     display_data,
    output logic [CH_W-1:0] channel,
    output logic            power_on,
    output logic            ch_changed
);

    localparam int AW = (CH_W + 1 > 7) ? CH_W + 1 : 7;
    localparam int TW = ($clog2(ENTRY_TIMEOUT) > 26) ? $clog2(ENTRY_TIMEOUT) : 26;

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_ON    = 2'd1;
    localparam logic [1:0] S_ENTRY = 2'd2;

    localparam logic [7:0] C_POWER  = 8'h80;
    localparam logic [7:0] C_UP     = 8'h18;
    localparam logic [7:0] C_DN     = 8'h38;
    localparam logic [7:0] C_RECALL = 8'h58;

    logic [1:0]      state, state_d;
    logic [CH_W-1:0] prev_ch, ch_d, prev_d;
    logic [3:0]      d1, d1_d;
    logic [TW-1:0]   timer, tmr_d;
    logic            chg_d;

    logic            k_pwr, k_up, k_dn, k_rcl, k_dig;
    logic            in_on, in_ent;
    logic            on_dig, ent_dig, ent_tmo;
    logic [AW-1:0]   ch_x, up_t, dn_t, dval, tgt;
    logic            load, in_rng;

    always_comb begin
        k_pwr = 1'b0;
        k_up  = 1'b0;
        k_dn  = 1'b0;
        k_rcl = 1'b0;
        k_dig = 1'b0;
        if (ir_valid) begin
            case (ir_cmd)
                C_POWER:  k_pwr = 1'b1;
                C_UP:     k_up  = 1'b1;
                C_DN:     k_dn  = 1'b1;
                C_RECALL: k_rcl = 1'b1;
                8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4,
                8'hD5, 8'hD6, 8'hD7, 8'hD8, 8'hD9:
                          k_dig = 1'b1;
                default: ;
            endcase
        end
    end

    assign in_on   = (state == S_ON);
    assign in_ent  = (state == S_ENTRY);
    assign on_dig  = in_on & k_dig;
    assign ent_dig = in_ent & k_dig;
    // A valid command on the timeout edge wins over the auto-commit.
    assign ent_tmo = in_ent & ~ir_valid & (timer == '0);

    assign ch_x = AW'(channel);
    assign dval = AW'(d1) * AW'(10) + AW'(ir_cmd[3:0]);

    always_comb begin
        if (channel == CH_W'(CH_MAX))
            up_t = (WRAP != 0) ? AW'(CH_MIN) : ch_x;
        else
            up_t = ch_x + AW'(1);
        if (channel == CH_W'(CH_MIN))
            dn_t = (WRAP != 0) ? AW'(CH_MAX) : ch_x;
        else
            dn_t = ch_x - AW'(1);
    end

    always_comb begin
        state_d = state;
        d1_d    = d1;
        tmr_d   = timer;
        tgt     = ch_x;
        load    = 1'b0;
        if (in_ent && timer != '0)
            tmr_d = timer - TW'(1);
        if (state == S_OFF) begin
            if (k_pwr)
                state_d = S_ON;
        end else begin
            unique case (1'b1)
                ent_dig: begin
                    tgt     = dval;
                    load    = 1'b1;
                    state_d = S_ON;
                end
                ent_tmo: begin
                    tgt     = AW'(d1);
                    load    = 1'b1;
                    state_d = S_ON;
                end
                k_pwr: state_d = S_OFF;
                k_up: begin
                    tgt     = up_t;
                    load    = 1'b1;
                    state_d = S_ON;
                end
                k_dn: begin
                    tgt     = dn_t;
                    load    = 1'b1;
                    state_d = S_ON;
                end
                k_rcl: begin
                    tgt     = AW'(prev_ch);
                    load    = 1'b1;
                    state_d = S_ON;
                end
                on_dig: begin
                    d1_d    = ir_cmd[3:0];
                    tmr_d   = TW'(ENTRY_TIMEOUT - 1);
                    state_d = S_ENTRY;
                end
                default: ;
            endcase
        end
    end

    assign in_rng = (tgt >= AW'(CH_MIN)) && (tgt <= AW'(CH_MAX));

    // Every channel update (step, recall, entry) funnels through this rule.
    always_comb begin
        ch_d   = channel;
        prev_d = prev_ch;
        chg_d  = 1'b0;
        if (load && in_rng && (tgt != ch_x)) begin
            ch_d   = CH_W'(tgt);
            prev_d = channel;
            chg_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_OFF;
            channel    <= CH_W'(CH_MIN);
            prev_ch    <= CH_W'(CH_MIN);
            d1         <= '0;
            timer      <= '0;
            ch_changed <= 1'b0;
        end else begin
            state      <= state_d;
            channel    <= ch_d;
            prev_ch    <= prev_d;
            d1         <= d1_d;
            timer      <= tmr_d;
            ch_changed <= chg_d;
        end
    end

    logic [3:0] tens, units;

    always_comb begin
        tens = 4'd0;
        for (int i = 1; i < 10; i++)
            if (channel >= CH_W'(i * 10))
                tens = 4'(i);
        units = 4'(channel - CH_W'(10 * tens));
    end

    assign power_on = (state != S_OFF);

    always_comb begin
        case (state)
            S_OFF:   display_data = 20'h00000;
            S_ENTRY: display_data = {4'd12, 8'h00, d1, 4'd15};
            default: display_data = {4'd12, 8'h00, tens, units};
        endcase
    end

endmodule

// File: doc/tv_channel_ctrl.md
# tv_channel_ctrl

Parametrised IR-driven channel controller for the demodulator top level. It sits between the IR command decoder (`ir_cmd`/`ir_valid`) and the 7-segment display driver. It adds the following over the fixed single-range controller:
- configurable channel range;
- optional wrap-around;
- power toggle;
- two-digit direct channel entry with timeout;
- last-channel recall;
- a channel-change strobe.

## Interface
- CH_MIN, 1, lowest legal channel (≥0)
- CH_MAX, 64, highest legal channel (≤99, > CH_MIN, < 2**CH_W)
- CH_W, 7, width of channel outputs
- WRAP, 0, 1 = CH+ at CH_MAX goes to CH_MIN and CH- at CH_MIN goes to CH_MAX; 0 = saturate
- ENTRY_TIMEOUT, 50_000_000, cycles from first digit to auto-commit (≥2)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ir_cmd  input  8  decoded IR command byte, valid only with ir_valid
- ir_valid  input  1  one-cycle strobe qualifying ir_cmd
- display_data  output  20  five BCD nibbles for display driver, [19:16] leftmost
- channel  output  CH_W  current channel (registered)
- power_on  output  1  1 when state ≠ OFF
- ch_changed  output  1  one-cycle pulse when channel value changes

## Operation
- Command codes (fixed): POWER 8'h80, CH+ 8'h18, CH- 8'h38, RECALL 8'h58, digit d (0–9) = 8'hD0+d. All other codes are ignored.
- Registers: state {OFF, ON, ENTRY}, channel, prev_ch, entry digit d1 (4 b), timer (≥26 b).
- Reset: state OFF, channel = prev_ch = CH_MIN, d1 = 0, timer = 0, ch_changed = 0.
- OFF: only POWER acts, moving to ON. channel and prev_ch are retained across power-off.
- ON:
  - POWER → OFF.
  - CH+: channel+1. At CH_MAX: CH_MIN if WRAP, else unchanged.
  - CH-: mirror of CH+ at CH_MIN.
  - RECALL: swap channel and prev_ch.
  - Digit d: d1 ← d, timer ← ENTRY_TIMEOUT−1, state → ENTRY.
- ENTRY:
  - Digit d2: v = d1·10 + d2. If CH_MIN ≤ v ≤ CH_MAX, commit v; else discard. State → ON.
  - Timeout (timer == 0 with no ir_valid that cycle): commit d1 if in range, else discard. State → ON.
  - Any other valid code (POWER/CH+/CH-/RECALL) discards the entry and is executed as from ON in the same cycle.
  - Unknown codes are ignored; the timer keeps running.
- Commit / channel change rule: whenever the new channel ≠ channel, prev_ch ← old channel and ch_changed pulses. Equal value means no update and no pulse. A saturated CH+/CH- produces no pulse.
- Arithmetic on CH_W+1 bits; d1·10+d2 ≤ 99 is computed on 7 bits minimum.
- display_data (combinational from registers):
  - OFF: 20'h00000.
  - ON: {4'd12, 4'd0, 4'd0, tens, units} of channel.
  - ENTRY: {4'd12, 4'd0, 4'd0, d1, 4'd15}, where 15 = blank digit.

## Timing
- ir_valid is sampled on the rising edge. State, channel and ch_changed update on that same edge, giving 1-cycle latency to outputs. display_data follows combinationally.
- ch_changed is high for exactly the one cycle after the updating edge.
- Timer loads on the first-digit edge and decrements every cycle. Auto-commit occurs on the edge ENTRY_TIMEOUT cycles after the first-digit edge.
- A valid command arriving on the timeout edge takes priority over timeout.
- Back-to-back ir_valid on consecutive cycles is supported; each command is processed.
- Asynchronous reset mid-entry or mid-pulse forces the reset values immediately. Entry is lost.

## Test plan
- Reset, POWER, CH+ ×2, CH- → power_on=1, channel 1→2→3→2, ch_changed pulses 3×, display C0002 (20'hC0002).
- WRAP=0, CH_MAX=64: at channel 64 CH+ → stays 64, no pulse. WRAP=1: CH+ → 1, pulse; CH- at 1 → 64.
- Digit 4 then digit 2 → display C004F after first digit, channel 42 after second, prev_ch previous value; then RECALL → channel returns to previous, then RECALL → 42.
- ENTRY_TIMEOUT=20: digit 7 then idle → channel 7 exactly 20 cycles after digit edge. Digits 9,9 with CH_MAX=64 → discarded, channel unchanged, no pulse.
- In ENTRY, CH+ → entry aborted, channel+1. In ENTRY, POWER → OFF, display 0. Second POWER restores the same channel.
- rst_n low during ENTRY → state OFF, channel=CH_MIN, display 0 immediately. Unknown code 8'h52 in ON → no change.
